uart_tx_tick: RTL and testbench
===============================

# uart_tx_tick

Serial transmitter that consumes the one-cycle `clk_tick` pulse produced by the clock divider as its bit-period strobe and shifts out asynchronous UART frames on `tx`. It sits directly downstream of the clock divider, with its `tick` input wired to the divider's `clk_tick` output. Each serial bit lasts exactly one tick interval. Parallel data enters through a valid/ready handshake.

## Interface
- `DATA_BITS`, default 8: payload bits per frame, range 5–9.
- `PARITY_EN`, default 0: 1 inserts a parity bit after the data.
- `PARITY_ODD`, default 0: 0 selects even parity, 1 selects odd parity. Ignored when `PARITY_EN` = 0.
- `STOP_BITS`, default 1: number of stop bits, 1 or 2.
- `clk`  in  1  system clock. Single clock domain.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `tick`  in  1  bit-period strobe from the clock divider. Sampled on the `clk` rising edge.
- `tx_data`  in  DATA_BITS  payload. Sampled only on accept.
- `tx_valid`  in  1  payload available.
- `tx_ready`  out  1  block can accept a payload.
- `tx`  out  1  serial line. Idle high.
- `busy`  out  1  a frame is pending or in flight.
- `done`  out  1  one-cycle pulse at frame completion.

## Operation
- States: IDLE, SYNC, START, DATA, PARITY, STOP.
- IDLE:
  - `tx_ready`=1, `tx`=1, `busy`=0.
  - Accept occurs when `tx_valid`=1 and `tx_ready`=1 at a clock edge.
  - On accept: latch `tx_data` into the shift register, latch the parity bit, go to SYNC.
- SYNC: wait for the first tick. On tick, go to START.
  - This aligns the start bit to a full tick period.
- START: `tx`=0. On tick, go to DATA with bit counter = 0.
- DATA:
  - `tx` = shift register bit 0, so data goes out LSB first.
  - On tick: shift right, increment the counter.
  - After the tick that ends bit `DATA_BITS`-1, go to PARITY if `PARITY_EN`=1, otherwise go to STOP.
- PARITY:
  - `tx` = XOR of the latched data bits, inverted when `PARITY_ODD`=1.
  - On tick, go to STOP.
- STOP:
  - `tx`=1, held for `STOP_BITS` tick periods.
  - On the tick ending the last stop bit: go to IDLE and pulse `done` for one cycle.
- `busy`=1 in every state except IDLE.
- `tx_ready` = (state == IDLE).
- Bit counter width is $clog2(`DATA_BITS`+1). The stop counter is 1 bit.
- The counter resets to 0 on entry to DATA and on entry to STOP.
- `tx_data` changes outside the accept cycle have no effect.
- `tx_valid` held high while busy is ignored and the payload is not lost. The producer holds it until `tx_ready`.
- The parity bit is computed from the latched copy of the data, never from live `tx_data`.

## Timing
- Reset values, all asserted asynchronously on `rst_n`=0:
  - `tx`=1, `tx_ready`=1, `busy`=0, `done`=0.
  - State IDLE, counters 0, shift register 0.
- Reset mid-frame: `tx` returns high immediately, the frame is aborted, and `done` does not pulse.
- First clock after `rst_n` deasserts: accept is allowed.
- `tx`, `tx_ready`, `busy` and `done` are all registered.
- Accept at edge A: `tx_ready`=0 and `busy`=1 from A.
- First tick sampled at edge T1 > A: `tx`=0 from T1.
- Bit boundaries fall at the edges where `tick`=1 is sampled.
- Frame length in ticks: 1 (SYNC exit) + 1 (start) + `DATA_BITS` + `PARITY_EN` + `STOP_BITS`.
- Frame end at edge Tn: `done`=1, `tx_ready`=1 and `busy`=0 for the cycle following Tn.
  - A new accept is possible at edge Tn+1, giving back-to-back frames with no idle gap beyond the SYNC wait.
- `tick` coincident with accept, in IDLE: the accept is taken, the tick is ignored, and the block waits in SYNC for the next tick.
- `tick` sampled in IDLE: ignored, `tx` stays 1.
- `tick` held high continuously: the block advances one bit per clock. This is legal.
- Ticks never queue. A tick while in a state is consumed only by that state's transition.

## Test plan
- Basic 8N1 frame:
  - Stimulus: tick every 4 clocks, send 0xA5.
  - Required `tx` after SYNC: 0,1,0,1,0,0,1,0,1,1, each bit exactly 4 clocks.
  - `done` pulses once. `busy` is high from accept to the frame end.
- Parity:
  - `PARITY_EN`=1, `PARITY_ODD`=0, send 0x07: parity bit = 1.
  - `PARITY_ODD`=1, send 0x07: parity bit = 0.
  - `PARITY_EN`=1, send 0x00 with even parity: parity bit = 0.
- Back-to-back:
  - Stimulus: `tx_valid` held high with 0x55, then 0xAA presented on `tx_ready`.
  - Required: second accept one cycle after `done`. Both frames are bit-exact, and 0xAA is not corrupted while 0x55 is in flight.
- Reset mid-frame:
  - Stimulus: `rst_n` pulsed low during data bit 3.
  - Required: `tx`=1 within the same cycle, no `done`, `tx_ready`=1. The next frame 0x3C transmits correctly.
- Tick edge cases:
  - Ticks while idle: `tx` stays 1.
  - Tick on the accept cycle: the start bit waits for the next tick.
  - `tick` tied high: each bit lasts 1 clock.
- `STOP_BITS`=2, `DATA_BITS`=7:
  - Send 0x41. Required: 7 data bits LSB first, then 2 high stop ticks before `done`.

Source files
------------

// File: rtl/uart_tx_tick_if.sv
// Parallel payload handshake into the tick-driven UART transmitter.
// A transfer happens on the clk edge where tx_valid and tx_ready are both high.
interface uart_tx_tick_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );
endinterface

// File: rtl/uart_tx_tick.sv
// UART frame transmitter paced by a one-cycle bit-period strobe (tick).
// Frame: SYNC wait, start bit, DATA_BITS LSB first, optional parity, STOP_BITS stop bits.
module uart_tx_tick #(
  parameter int DATA_BITS  = 8,
  parameter bit PARITY_EN  = 1'b0,
  parameter bit PARITY_ODD = 1'b0,
  parameter int STOP_BITS  = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                tick,
  uart_tx_tick_if.slave       bus,
  output logic                tx,
  output logic                busy,
  output logic                done,
  output logic [2:0]          state_dbg
);

  localparam int CNT_W = $clog2(DATA_BITS + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SYNC   = 3'd1,
    S_START  = 3'd2,
    S_DATA   = 3'd3,
    S_PARITY = 3'd4,
    S_STOP   = 3'd5
  } state_t;

  state_t               state, state_nxt;
  logic [CNT_W-1:0]     bit_cnt, bit_cnt_nxt;
  logic                 stop_cnt, stop_cnt_nxt;
  logic [DATA_BITS-1:0] shreg, shreg_nxt;
  logic                 par, par_nxt;
  logic                 tx_nxt, ready_nxt, busy_nxt, done_nxt;
  logic                 ready_q;
  logic                 accept;
  logic                 last_data, last_stop;

  // ready_q is high exactly in IDLE, so accept can only happen there.
  assign accept    = bus.tx_valid && ready_q;
  assign last_data = (bit_cnt == CNT_W'(DATA_BITS - 1));
  assign last_stop = (stop_cnt == 1'(STOP_BITS - 1));

  assign bus.tx_ready = ready_q;
  assign state_dbg    = state;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; a tick only advances the state that samples it.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (accept) state_nxt = S_SYNC;
      S_SYNC:   if (tick) state_nxt = S_START;
      S_START:  if (tick) state_nxt = S_DATA;
      S_DATA:   if (tick && last_data) state_nxt = PARITY_EN ? S_PARITY : S_STOP;
      S_PARITY: if (tick) state_nxt = S_STOP;
      S_STOP:   if (tick && last_stop) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Datapath next values: shift register, parity latch and counters.
  always_comb begin
    shreg_nxt    = shreg;
    par_nxt      = par;
    bit_cnt_nxt  = bit_cnt;
    stop_cnt_nxt = stop_cnt;
    if (state == S_IDLE && accept) begin
      shreg_nxt = bus.tx_data;
      par_nxt   = (^bus.tx_data) ^ PARITY_ODD;
    end
    if (state == S_DATA && tick) begin
      shreg_nxt   = shreg >> 1;
      bit_cnt_nxt = bit_cnt + CNT_W'(1);
    end
    if (state == S_STOP && tick && !last_stop) begin
      stop_cnt_nxt = stop_cnt + 1'b1;
    end
    if (state_nxt == S_DATA && state != S_DATA) begin
      bit_cnt_nxt = '0;
    end
    if (state_nxt == S_STOP && state != S_STOP) begin
      stop_cnt_nxt = 1'b0;
    end
  end

  // Outputs are registered, so they are derived from the next state.
  always_comb begin
    case (state_nxt)
      S_START:  tx_nxt = 1'b0;
      S_DATA:   tx_nxt = shreg_nxt[0];
      S_PARITY: tx_nxt = par_nxt;
      default:  tx_nxt = 1'b1;
    endcase
    ready_nxt = (state_nxt == S_IDLE);
    busy_nxt  = (state_nxt != S_IDLE);
    done_nxt  = (state == S_STOP) && (state_nxt == S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg    <= '0;
      par      <= 1'b0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      tx       <= 1'b1;
      ready_q  <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      shreg    <= shreg_nxt;
      par      <= par_nxt;
      bit_cnt  <= bit_cnt_nxt;
      stop_cnt <= stop_cnt_nxt;
      tx       <= tx_nxt;
      ready_q  <= ready_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
    end
  end

endmodule

// File: tb/tb_uart_tx_tick.sv
// Bench for uart_tx_tick: four configurations (8N1, 8E1, 8O1, 7N2) on shared clk/rst/tick.
// A per-instance line monitor decodes frames and checks them against queued expectations.
module tb_uart_tx_tick;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       tick;
  logic [8:0] data_r;
  logic [3:0] valid_r;
  wire  [3:0] rdy_w, tx_w, busy_w, done_w;
  wire  [2:0] st0, st1, st2, st3;

  int checks = 0;
  int errors = 0;

  int db_a  [4] = '{8, 8, 8, 7};
  int pe_a  [4] = '{0, 1, 1, 0};
  int sb_a  [4] = '{1, 1, 1, 2};
  int len_a [4] = '{10, 11, 11, 10};

  // {dut[1:0], bit period in clocks[7:0], line bits[12:0] with bit 0 = start bit}
  logic [22:0] exp_q[$];

  int   tick_per;
  logic man_tick;
  int   cyc;
  logic acc_done;

  uart_tx_tick_if #(.DATA_BITS(8)) bus0 ();
  uart_tx_tick_if #(.DATA_BITS(8)) bus1 ();
  uart_tx_tick_if #(.DATA_BITS(8)) bus2 ();
  uart_tx_tick_if #(.DATA_BITS(7)) bus3 ();

  assign bus0.tx_data = data_r[7:0];
  assign bus1.tx_data = data_r[7:0];
  assign bus2.tx_data = data_r[7:0];
  assign bus3.tx_data = data_r[6:0];
  assign bus0.tx_valid = valid_r[0];
  assign bus1.tx_valid = valid_r[1];
  assign bus2.tx_valid = valid_r[2];
  assign bus3.tx_valid = valid_r[3];
  assign rdy_w[0] = bus0.tx_ready;
  assign rdy_w[1] = bus1.tx_ready;
  assign rdy_w[2] = bus2.tx_ready;
  assign rdy_w[3] = bus3.tx_ready;

  uart_tx_tick #(.DATA_BITS(8), .PARITY_EN(1'b0), .PARITY_ODD(1'b0), .STOP_BITS(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .tick(tick), .bus(bus0),
    .tx(tx_w[0]), .busy(busy_w[0]), .done(done_w[0]), .state_dbg(st0));
  uart_tx_tick #(.DATA_BITS(8), .PARITY_EN(1'b1), .PARITY_ODD(1'b0), .STOP_BITS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .tick(tick), .bus(bus1),
    .tx(tx_w[1]), .busy(busy_w[1]), .done(done_w[1]), .state_dbg(st1));
  uart_tx_tick #(.DATA_BITS(8), .PARITY_EN(1'b1), .PARITY_ODD(1'b1), .STOP_BITS(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .tick(tick), .bus(bus2),
    .tx(tx_w[2]), .busy(busy_w[2]), .done(done_w[2]), .state_dbg(st2));
  uart_tx_tick #(.DATA_BITS(7), .PARITY_EN(1'b0), .PARITY_ODD(1'b0), .STOP_BITS(2)) dut3 (
    .clk(clk), .rst_n(rst_n), .tick(tick), .bus(bus3),
    .tx(tx_w[3]), .busy(busy_w[3]), .done(done_w[3]), .state_dbg(st3));

  // Tick source: periodic when tick_per > 0, otherwise follows man_tick.
  initial begin
    tick = 1'b0;
    cyc  = 0;
    forever begin
      @(posedge clk);
      #2;
      cyc++;
      if (tick_per == 0) tick = man_tick;
      else               tick = ((cyc % tick_per) == 0);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_frame(input int k, input logic [8:0] d, input logic p, input int per);
    logic [12:0] f;
    int n;
    logic [1:0] kk;
    logic [7:0] pp;
    f = '0;
    n = 0;
    f[n] = 1'b0; n++;
    for (int i = 0; i < db_a[k]; i++) begin f[n] = d[i]; n++; end
    if (pe_a[k] != 0) begin f[n] = p; n++; end
    for (int s = 0; s < sb_a[k]; s++) begin f[n] = 1'b1; n++; end
    kk = k[1:0];
    pp = per[7:0];
    exp_q.push_back({kk, pp, f});
  endtask

  // Line monitor: a bit boundary is a clk edge that sampled tick=1.
  task automatic mon(input int k);
    logic        prev_tick = 1'b0;
    logic        prev_tx = 1'b1;
    logic        in_frame = 1'b0;
    logic        frame_end;
    logic [12:0] cap = '0;
    int          dur [13];
    int          nb = 0;
    int          run = 0;
    int          bad;
    logic [22:0] e;
    forever begin
      @(negedge clk);
      frame_end = 1'b0;
      if (!rst_n) begin
        in_frame  = 1'b0;
        prev_tick = 1'b0;
        prev_tx   = 1'b1;
      end else begin
        if (prev_tick && in_frame) begin
          cap[nb] = prev_tx;
          dur[nb] = run;
          nb++;
          run = 1;
          if (nb == len_a[k]) begin
            frame_end = 1'b1;
            in_frame  = 1'b0;
            chk($sformatf("done_at_end_%0d", k), done_w[k], 1);
            chk($sformatf("busy_at_end_%0d", k), busy_w[k], 0);
            chk($sformatf("sb_has_entry_%0d", k), exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
              e = exp_q.pop_front();
              chk($sformatf("frame_dut_%0d", k), k, e[22:21]);
              chk($sformatf("frame_bits_%0d", k), cap, e[12:0]);
              bad = int'(e[20:13]);
              for (int i = 0; i < nb; i++) if (dur[i] != int'(e[20:13])) bad = dur[i];
              chk($sformatf("bit_period_%0d", k), bad, e[20:13]);
            end
          end
        end else if (prev_tick && !in_frame && tx_w[k] == 1'b0) begin
          in_frame = 1'b1;
          nb  = 0;
          run = 1;
          cap = '0;
        end else if (in_frame) begin
          run++;
        end
        if (done_w[k]) chk($sformatf("done_only_at_end_%0d", k), frame_end, 1);
        prev_tick = tick;
        prev_tx   = tx_w[k];
      end
    end
  endtask

  initial mon(0);
  initial mon(1);
  initial mon(2);
  initial mon(3);

  // Driver: called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input int k, input logic [8:0] d, input bit hold);
    int n;
    data_r     = d;
    valid_r[k] = 1'b1;
    n = 0;
    while (rdy_w[k] !== 1'b1 && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    acc_done = done_w[k];
    chk($sformatf("accept_wait_%0d", k), n < 2000, 1);
    @(posedge clk); #1;
    if (!hold) valid_r[k] = 1'b0;
    chk($sformatf("accept_busy_%0d", k), busy_w[k], 1);
    chk($sformatf("accept_ready_%0d", k), rdy_w[k], 0);
  endtask

  task automatic wait_idle(input int k);
    int n;
    n = 0;
    while (busy_w[k] && n < 5000) begin
      @(posedge clk); #1;
      n++;
    end
    chk($sformatf("idle_wait_%0d", k), n < 5000, 1);
    repeat (2) begin @(posedge clk); #1; end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] idle_and;
    logic [3:0] busy_or;
    int n;
    rst_n    = 1'b0;
    valid_r  = '0;
    data_r   = '0;
    tick_per = 0;
    man_tick = 1'b0;
    acc_done = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    chk("rst_tx", tx_w, 4'hF);
    chk("rst_ready", rdy_w, 4'hF);
    chk("rst_busy", busy_w, 4'h0);
    chk("rst_done", done_w, 4'h0);
    chk("rst_state", {st3, st2, st1, st0}, 12'h000);

    // ticks while idle
    tick_per = 2;
    idle_and = 4'hF;
    busy_or  = 4'h0;
    repeat (20) begin
      @(posedge clk); #1;
      idle_and &= tx_w;
      busy_or  |= busy_w;
    end
    chk("idle_ticks_tx", idle_and, 4'hF);
    chk("idle_ticks_busy", busy_or, 4'h0);

    // basic 8N1, payload scrambled while in flight
    tick_per = 4;
    expect_frame(0, 9'h0A5, 1'b0, 4);
    send(0, 9'h0A5, 1'b0);
    data_r = 9'(($urandom_range(0, 511)));
    wait_idle(0);

    // parity: even 0x07 -> 1, even 0x00 -> 0, odd 0x07 -> 0
    expect_frame(1, 9'h007, 1'b1, 4);
    send(1, 9'h007, 1'b0);
    wait_idle(1);
    expect_frame(1, 9'h000, 1'b0, 4);
    send(1, 9'h000, 1'b0);
    wait_idle(1);
    expect_frame(2, 9'h007, 1'b0, 4);
    send(2, 9'h007, 1'b0);
    wait_idle(2);

    // back-to-back: valid stays high, next payload presented while busy
    expect_frame(0, 9'h055, 1'b0, 4);
    expect_frame(0, 9'h0AA, 1'b0, 4);
    send(0, 9'h055, 1'b1);
    data_r = 9'h0AA;
    send(0, 9'h0AA, 1'b0);
    chk("b2b_accept_after_done", acc_done, 1);
    wait_idle(0);

    // reset during data bit 3 of 0xF0 (bit 3 is 0)
    send(0, 9'h0F0, 1'b0);
    n = 0;
    while (tx_w[0] !== 1'b0 && n < 100) begin @(posedge clk); #1; n++; end
    chk("start_seen", n < 100, 1);
    repeat (18) @(posedge clk);
    #1;
    chk("pre_reset_bit3", tx_w[0], 0);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_tx", tx_w[0], 1);
    chk("abort_ready", rdy_w[0], 1);
    chk("abort_busy", busy_w[0], 0);
    chk("abort_done", done_w[0], 0);
    @(posedge clk); #1 rst_n = 1'b1;
    expect_frame(0, 9'h03C, 1'b0, 4);
    send(0, 9'h03C, 1'b0);
    wait_idle(0);

    // tick coincident with accept: start bit waits for the next tick
    tick_per = 0;
    man_tick = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    expect_frame(0, 9'h0C3, 1'b0, 3);
    data_r     = 9'h0C3;
    valid_r[0] = 1'b1;
    man_tick   = 1'b1;
    @(posedge clk); #1;
    valid_r[0] = 1'b0;
    man_tick   = 1'b0;
    chk("tick_acc_busy", busy_w[0], 1);
    chk("tick_acc_tx", tx_w[0], 1);
    repeat (3) begin @(posedge clk); #1; end
    chk("tick_acc_sync_tx", tx_w[0], 1);
    for (int i = 0; i < 11; i++) begin
      man_tick = 1'b1;
      @(posedge clk); #1;
      man_tick = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
    end
    wait_idle(0);

    // tick tied high: one clock per bit
    tick_per = 1;
    expect_frame(0, 9'h096, 1'b0, 1);
    send(0, 9'h096, 1'b0);
    wait_idle(0);

    // 7 data bits, 2 stop bits
    tick_per = 4;
    expect_frame(3, 9'h041, 1'b0, 4);
    send(3, 9'h041, 1'b0);
    wait_idle(3);

    repeat (5) begin @(posedge clk); #1; end
    chk("sb_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
